// File: rtl/addsub_pkg.sv
// Shared types and defaults for the sequential chunked adder/subtractor.
package addsub_pkg;

    localparam int W_DEF = 32;
    localparam int K_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Chunk index width; a single-chunk configuration still keeps one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
// io_Ovf exists only when ADDSUB_SEQ_OVF_EN is defined.
interface addsub_seq_if
    import addsub_pkg::*;
    #(parameter int W = W_DEF) ();

    logic         io_in_valid;
    logic         io_in_ready;
    logic [W-1:0] io_A;
    logic [W-1:0] io_B;
    logic         io_Cin;
    logic         io_Sub;
    logic         io_out_valid;
    logic         io_out_ready;
    logic [W-1:0] io_Sum;
    logic         io_Cout;
    logic         io_Zero;
`ifdef ADDSUB_SEQ_OVF_EN
    logic         io_Ovf;
`endif

    modport master (
`ifdef ADDSUB_SEQ_OVF_EN
        input  io_Ovf,
`endif
        output io_in_valid, io_A, io_B, io_Cin, io_Sub, io_out_ready,
        input  io_in_ready, io_out_valid, io_Sum, io_Cout, io_Zero
    );

    modport slave (
`ifdef ADDSUB_SEQ_OVF_EN
        output io_Ovf,
`endif
        input  io_in_valid, io_A, io_B, io_Cin, io_Sub, io_out_ready,
        output io_in_ready, io_out_valid, io_Sum, io_Cout, io_Zero
    );

endinterface

// File: rtl/addsub_seq_chunk_adder.sv
// Combinational K-bit ripple adder; cmsb is the carry into bit K-1.
module chunk_adder
    import addsub_pkg::*;
    #(parameter int K = K_DEF) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [K:0] c_s;

    // Bit-serial ripple through the chunk.
    always_comb begin
        c_s    = {(K+1){1'b0}};
        s      = {K{1'b0}};
        c_s[0] = cin;
        for (int i = 0; i < K; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
        cout = c_s[K];
        cmsb = c_s[K-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// Sequential add/subtract: one K-bit chunk per cycle, W/K cycles per operation.
// Optional signed-overflow output is enabled with the macro ADDSUB_SEQ_OVF_EN.
module addsub_seq
    import addsub_pkg::*;
    #(
    parameter int W = W_DEF,
    parameter int K = K_DEF
) (
    input  logic        clock,
    input  logic        reset,
    addsub_seq_if.slave io
);

    localparam int N     = (K > 0) ? (W / K) : 1;
    localparam int IDX_W = idx_width(N);

    if ((K < 1) || (K > W) || ((W % K) != 0)) begin : g_bad_cfg
        $error("addsub_seq: K must divide W and satisfy 1 <= K <= W");
    end

    state_e             state_r;
    state_e             state_nxt_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic               cout_r;
    logic               zero_r;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               last_s;
    logic [K-1:0]       chunk_a_s;
    logic [K-1:0]       chunk_b_s;
    logic [K-1:0]       chunk_sum_s;
    logic               chunk_cout_s;
    logic               chunk_cmsb_s;
    logic [W-1:0]       sum_nxt_s;

    chunk_adder #(.K(K)) u_chunk_adder (
        .a    (chunk_a_s),
        .b    (chunk_b_s),
        .cin  (carry_r),
        .s    (chunk_sum_s),
        .cout (chunk_cout_s),
        .cmsb (chunk_cmsb_s)
    );

    // Select the active chunk and splice its sum into the running result.
    always_comb begin
        chunk_a_s = a_r[int'(idx_r) * K +: K];
        chunk_b_s = b_r[int'(idx_r) * K +: K];
        sum_nxt_s = sum_r;
        sum_nxt_s[int'(idx_r) * K +: K] = chunk_sum_s;
        last_s    = (idx_r == IDX_W'(N - 1));
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; operand inputs only matter in IDLE, out_ready only in DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (io.io_in_valid) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (io.io_out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            BUSY:    in_ready_s  = 1'b0;
            DONE:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Operand capture and per-chunk accumulation; subtract is A + ~B + !borrow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            cout_r  <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.io_in_valid) begin
                        a_r     <= io.io_A;
                        b_r     <= io.io_Sub ? ~io.io_B : io.io_B;
                        carry_r <= io.io_Cin ^ io.io_Sub;
                        idx_r   <= {IDX_W{1'b0}};
                        sum_r   <= {W{1'b0}};
                        cout_r  <= 1'b0;
                        zero_r  <= 1'b0;
                    end
                end
                BUSY: begin
                    sum_r   <= sum_nxt_s;
                    carry_r <= chunk_cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        cout_r <= chunk_cout_s;
                        zero_r <= (sum_nxt_s == {W{1'b0}});
                    end
                end
                default: begin
                    sum_r <= sum_r;
                end
            endcase
        end
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_r;

    // Signed overflow taken from the MSB chunk's carries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (io.io_in_valid) begin
                        ovf_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (last_s) begin
                        ovf_r <= chunk_cmsb_s ^ chunk_cout_s;
                    end
                end
                default: ovf_r <= ovf_r;
            endcase
        end
    end

    assign io.io_Ovf = ovf_r;
`else
    logic unused_cmsb_s;
    assign unused_cmsb_s = chunk_cmsb_s;
`endif

    assign io.io_in_ready  = in_ready_s;
    assign io.io_out_valid = out_valid_s;
    assign io.io_Sum       = sum_r;
    assign io.io_Cout      = cout_r;
    assign io.io_Zero      = zero_r;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter K, default 8, meaning the chunk width added per cycle; W % K == 0 and 1 <= K <= W, with elaboration failing otherwise.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port io_in_valid, input, 1, meaning the operands are offered.
REQ-006 The block SHALL have port io_in_ready, output, 1, meaning the block accepts operands.
REQ-007 The block SHALL have ports io_A and io_B, input, W each, meaning the unsigned or two's-complement operands.
REQ-008 The block SHALL have port io_Cin, input, 1, meaning carry-in for add or borrow-in for subtract.
REQ-009 The block SHALL have port io_Sub, input, 1, selecting subtract (1) or add (0).
REQ-010 The block SHALL have port io_out_valid, output, 1, meaning the result is valid.
REQ-011 The block SHALL have port io_out_ready, input, 1, meaning the consumer takes the result.
REQ-012 The block SHALL have port io_Sum, output, W, meaning the result.
REQ-013 The block SHALL have ports io_Cout and io_Zero, output, 1 each, meaning carry-out and result == 0.
REQ-014 The block SHALL have port io_Ovf, output, 1, meaning signed overflow; it is present only per REQ-028.

Function
REQ-015 The FSM SHALL use states IDLE, BUSY and DONE, with io_in_ready = 1 only in IDLE and io_out_valid = 1 only in DONE.
REQ-016 On an io_in_valid & io_in_ready edge, the block SHALL latch A, B' = io_Sub ? ~io_B : io_B, and carry c0 = io_Cin ^ io_Sub, clear chunk index idx, and enter BUSY.
REQ-017 In BUSY, each edge SHALL add chunk idx of A, B' and the running carry, write that chunk of the result, update the carry, and increment idx.
REQ-018 The block SHALL leave BUSY for DONE on the edge processing chunk N-1 (N = W/K), so io_out_valid is visible N cycles after the acceptance edge; K == W gives latency 1.
REQ-019 io_Cout SHALL be the final carry (for subtract, 1 = no borrow), and io_Zero SHALL be (io_Sum == 0).
REQ-020 Arithmetic SHALL be modulo 2^W; for example, sub with Cin=0 yields A-B and with Cin=1 yields A-B-1.
REQ-021 In DONE, all outputs SHALL be held stable until io_out_ready = 1; the block SHALL return to IDLE on that edge.
REQ-022 The block SHALL ignore io_in_valid, io_A, io_B, io_Cin and io_Sub while in BUSY or DONE, with no overlap or queuing.
REQ-023 io_out_ready SHALL be ignored outside DONE.

Reset
REQ-024 On reset assertion, the state SHALL be IDLE, io_in_ready = 1, io_out_valid = 0, and io_Sum, io_Cout, io_Zero and io_Ovf = 0, with all internal registers and idx at 0.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation without producing a result.
REQ-026 After reset release, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-027 The block SHALL support the macro ADDSUB_SEQ_OVF_EN.
REQ-028 With ADDSUB_SEQ_OVF_EN defined, the block SHALL register io_Ovf = carry-into-MSB ^ carry-out-of-MSB, captured on the last chunk and valid with io_out_valid; without it, port io_Ovf and its logic SHALL be absent.

Structure
REQ-029 The shared package addsub_pkg SHALL hold the state enum typedef (IDLE/BUSY/DONE) and the default constants W_DEF=32 and K_DEF=8.
REQ-030 The block SHALL instantiate one sub-module, chunk_adder: a combinational K-bit ripple adder with inputs a, b and cin, and outputs s, cout and cmsb (carry into bit K-1).
REQ-031 The index counter SHALL be $clog2(N) bits wide, with a minimum of 1.

Verification
REQ-032 With W=32 and K=8, adding 0xFFFFFFFF + 0x00000001 with Cin=0 SHALL give out_valid 4 cycles after accept, Sum=0, Cout=1, Zero=1, Ovf=0.
REQ-033 Subtracting 5 - 7 with Cin=0 SHALL give Sum=0xFFFFFFFE, Cout=0, Zero=0, Ovf=0, and subtracting 7 - 5 SHALL give Sum=2, Cout=1.
REQ-034 Adding 0x7FFFFFFF + 1 SHALL give Sum=0x80000000 and Ovf=1; subtracting 0x80000000 - 1 SHALL give Ovf=1; with the macro undefined, the build SHALL have no io_Ovf port.
REQ-035 Holding io_out_ready=0 for 10 cycles in DONE SHALL keep the outputs stable and io_in_ready=0; with io_in_valid held high and new operands applied, they SHALL not be accepted until return to IDLE.
REQ-036 Asserting reset in the 2nd BUSY cycle SHALL immediately zero out_valid and Sum, and set in_ready=1; the next operation SHALL then be correct.
REQ-037 With W=8 and K=8, 200 + 100 with Cin=1 SHALL give latency 1, Sum=0x2D, Cout=1; a random back-to-back run of 1000 operations SHALL match a reference model.
